// File: rtl/weight_ram_reader.sv
// weight_ram_reader
//   Streams a burst of weight words out of a synchronous-read WeightRAM to a
//   valid/ready consumer. The RAM is only ever read (RamWE tied low).
//
// Ports
//   Clock     in   1        system clock, rising edge
//   Rst       in   1        asynchronous active-low reset
//   Start     in   1        begin a burst (ignored unless idle)
//   BaseAddr  in   AW       first address of the burst
//   Count     in   AW+1     number of addresses to read (0..2^AW)
//   RamAddr   out  AW       address to WeightRAM
//   RamWE     out  1        write enable to WeightRAM, constant 0
//   RamQ      in   N*DW     RAM read data, one cycle after RamAddr
//   Valid     out  1        Data/Last hold a beat
//   Ready     in   1        consumer accepts the beat
//   Data      out  N*DW     weight word, same packing as RamQ
//   Last      out  1        current beat is the final one of the burst
//   Busy      out  1        burst in progress
//   Done      out  1        one-cycle burst-complete pulse
module weight_ram_reader #(
   parameter int N  = 10,
   parameter int DW = 10,
   parameter int AW = 7
) (
   input  logic              Clock,
   input  logic              Rst,
   input  logic              Start,
   input  logic [AW-1:0]     BaseAddr,
   input  logic [AW:0]       Count,
   output logic [AW-1:0]     RamAddr,
   output logic              RamWE,
   input  logic [N*DW-1:0]   RamQ,
   output logic              Valid,
   input  logic              Ready,
   output logic [N*DW-1:0]   Data,
   output logic              Last,
   output logic              Busy,
   output logic              Done
);

   localparam int WW = N * DW;

   typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} state_t;

   state_t             r_state;
   state_t             w_next;
   logic [AW-1:0]      r_addr;
   logic [AW:0]        r_rem;
   logic               r_vld_p0;
   logic               r_last_p0;
   logic [1:0][WW-1:0] r_buf_data;
   logic [1:0]         r_buf_last;
   logic               r_rd_ptr;
   logic               r_wr_ptr;
   logic [1:0]         r_occ;

   logic               w_pop;
   logic               w_push;
   logic [1:0]         w_used;
   logic               w_issue;
   logic               w_final_issue;
   logic               w_load;

   assign w_pop  = Valid & Ready;
   assign w_push = r_vld_p0;

   // Credit counts the entry leaving this cycle as already free, so a
   // continuously accepting consumer sees one beat per cycle while the
   // buffer can still never be asked to hold more than two words.
   assign w_used        = r_occ - {1'b0, w_pop} + {1'b0, r_vld_p0};
   assign w_issue       = (r_state == READ) && (w_used < 2'd2);
   assign w_final_issue = w_issue && (r_rem == (AW+1)'(1));
   assign w_load        = (r_state == IDLE) && Start && (Count != '0);

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (Start) w_next = (Count != '0) ? READ : FINISH;
         READ:    if (w_final_issue) w_next = DRAIN;
         DRAIN:   if (w_pop && Last) w_next = FINISH;
         FINISH:  w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge Rst) begin
      if (!Rst) r_state <= IDLE;
      else      r_state <= w_next;
   end

   // Address generation. The address is held on the final issue so RamAddr
   // never shows an address beyond the burst.
   always_ff @(posedge Clock or negedge Rst) begin
      if (!Rst) begin
         r_addr <= '0;
         r_rem  <= '0;
      end else if (w_load) begin
         r_addr <= BaseAddr;
         r_rem  <= Count;
      end else if (w_issue) begin
         if (!w_final_issue) r_addr <= r_addr + 1'b1;
         r_rem <= r_rem - 1'b1;
      end
   end

   // p0: address sampled by the RAM; its data and Last tag arrive next edge
   always_ff @(posedge Clock or negedge Rst) begin
      if (!Rst) begin
         r_vld_p0  <= 1'b0;
         r_last_p0 <= 1'b0;
      end else begin
         r_vld_p0  <= w_issue;
         r_last_p0 <= w_final_issue;
      end
   end

   // p1: two-entry skid buffer, Last stored alongside its data word
   always_ff @(posedge Clock or negedge Rst) begin
      if (!Rst) begin
         r_buf_data <= '0;
         r_buf_last <= '0;
         r_rd_ptr   <= 1'b0;
         r_wr_ptr   <= 1'b0;
         r_occ      <= '0;
      end else begin
         if (w_push) begin
            r_buf_data[r_wr_ptr] <= RamQ;
            r_buf_last[r_wr_ptr] <= r_last_p0;
            r_wr_ptr             <= ~r_wr_ptr;
         end
         if (w_pop) r_rd_ptr <= ~r_rd_ptr;
         r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

   assign RamAddr = r_addr;
   assign RamWE   = 1'b0;
   assign Valid   = (r_occ != 2'd0);
   assign Data    = r_buf_data[r_rd_ptr];
   assign Last    = Valid & r_buf_last[r_rd_ptr];
   assign Busy    = (r_state == READ) || (r_state == DRAIN);
   assign Done    = (r_state == FINISH);

endmodule

// File: tb/tb_weight_ram_reader.sv
module tb_weight_ram_reader;

   localparam int N  = 10;
   localparam int DW = 10;
   localparam int AW = 7;
   localparam int WW = N * DW;
   localparam int DEPTH = 1 << AW;

   logic            Clock;
   logic            Rst;
   logic            Start;
   logic [AW-1:0]   BaseAddr;
   logic [AW:0]     Count;
   logic [AW-1:0]   RamAddr;
   logic            RamWE;
   logic [WW-1:0]   RamQ;
   logic            Valid;
   logic            Ready;
   logic [WW-1:0]   Data;
   logic            Last;
   logic            Busy;
   logic            Done;

   int n_pass  = 0;
   int n_total = 0;

   logic [WW-1:0] mem [DEPTH];

   weight_ram_reader #(.N(N), .DW(DW), .AW(AW)) dut (
      .Clock(Clock), .Rst(Rst), .Start(Start), .BaseAddr(BaseAddr),
      .Count(Count), .RamAddr(RamAddr), .RamWE(RamWE), .RamQ(RamQ),
      .Valid(Valid), .Ready(Ready), .Data(Data), .Last(Last),
      .Busy(Busy), .Done(Done)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Synchronous-read RAM model
   initial RamQ = '0;
   always @(posedge Clock) RamQ <= mem[RamAddr];

   // Every neuron slot of the word at address a holds a
   function automatic logic [WW-1:0] word_of(input int a);
      logic [WW-1:0] w;
      for (int i = 0; i < N; i++) w[i*DW +: DW] = DW'(a % DEPTH);
      return w;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic chkw(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ramaddr"}, int'(RamAddr), 0);
      chk({tag, "_ramwe"},   int'(RamWE), 0);
      chk({tag, "_valid"},   int'(Valid), 0);
      chkw({tag, "_data"},   Data, '0);
      chk({tag, "_last"},    int'(Last), 0);
      chk({tag, "_busy"},    int'(Busy), 0);
      chk({tag, "_done"},    int'(Done), 0);
   endtask

   // Runs one burst from a negedge. Expected beats come from the address
   // arithmetic (base+k) mod DEPTH; Ready for the j-th Valid cycle is pat[j%32].
   task automatic run_burst(input int base, input int cnt, input logic [31:0] pat,
                            input bit poke, output int nbeats,
                            output int firstw, output int lastw);
      int idx = 0, vcnt = 0, first_v = -1, last_acc = -1, done_cyc = -1, ndone = 0;
      logic [AW-1:0] addr_log [$];
      logic [AW-1:0] ra0;
      logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
      logic [WW-1:0] pd = '0;
      firstw = -1;
      lastw  = -1;
      ra0 = RamAddr;
      BaseAddr = AW'(base);
      Count    = (AW+1)'(cnt);
      Start    = 1'b1;
      Ready    = 1'b0;
      for (int k = 0; k < 600; k++) begin
         @(negedge Clock);
         if (poke && k == 3) begin
            Start = 1'b1; BaseAddr = 7'd50; Count = 8'd7;
         end else begin
            Start = 1'b0;
         end
         if (k == 0) chk("busy_at_start", int'(Busy), int'(cnt > 0));
         if (Busy && (addr_log.size() == 0 || addr_log[$] != RamAddr))
            addr_log.push_back(RamAddr);
         if (Valid && first_v < 0) first_v = k;
         if (pv && !pr) begin
            chk("stall_valid", int'(Valid), 1);
            chkw("stall_data", Data, pd);
            chk("stall_last", int'(Last), int'(pl));
         end
         if (Valid) begin
            Ready = pat[vcnt % 32];
            vcnt++;
         end else begin
            Ready = 1'($urandom_range(0, 1));
         end
         if (Valid && Ready) begin
            chkw("beat_data", Data, word_of(base + idx));
            chk("beat_last", int'(Last), int'(idx == cnt - 1));
            if (idx == 0) firstw = int'(Data[DW-1:0]);
            lastw = int'(Data[DW-1:0]);
            idx++;
            last_acc = k;
         end
         if (Done) begin
            ndone++;
            if (done_cyc < 0) done_cyc = k;
         end
         pv = Valid; pr = Ready; pd = Data; pl = Last;
         if (done_cyc >= 0 && k >= done_cyc + 3) break;
      end
      Ready = 1'b0;
      chk("done_seen", int'(done_cyc >= 0), 1);
      chk("beat_count", idx, cnt);
      chk("done_count", ndone, 1);
      chk("done_cycle", done_cyc, (cnt == 0) ? 0 : last_acc + 1);
      chk("first_valid_cycle", first_v, (cnt == 0) ? -1 : 2);
      chk("busy_after", int'(Busy), 0);
      chk("valid_after", int'(Valid), 0);
      if (pat == 32'hFFFF_FFFF && cnt > 0)
         chk("throughput", last_acc - first_v, cnt - 1);
      if (cnt == 0) begin
         chk("no_addr_issued", int'(RamAddr), int'(ra0));
      end else begin
         chk("addr_count", addr_log.size(), cnt);
         for (int i = 0; i < addr_log.size() && i < cnt; i++)
            chk("addr_seq", int'(addr_log[i]), (base + i) % DEPTH);
      end
      nbeats = idx;
   endtask

   typedef struct {
      int          base;
      int          cnt;
      logic [31:0] pat;
      bit          poke;
      int          exp_n;
      int          exp_first;
      int          exp_last;
   } vec_t;

   initial begin
      vec_t vecs [6];
      int nb, fw, lw, acc, dcount;

      for (int a = 0; a < DEPTH; a++) mem[a] = word_of(a);

      vecs[0] = '{5,   3,   32'hFFFF_FFFF, 1'b0, 3,   5,   7};
      vecs[1] = '{126, 4,   32'hFFFF_FFFF, 1'b0, 4,   126, 1};
      vecs[2] = '{0,   6,   32'hFFFF_FFE9, 1'b0, 6,   0,   5};
      vecs[3] = '{33,  0,   32'hFFFF_FFFF, 1'b0, 0,   -1,  -1};
      vecs[4] = '{0,   4,   32'hFFFF_FFFF, 1'b1, 4,   0,   3};
      vecs[5] = '{100, 128, 32'hA5A5_5A5A, 1'b0, 128, 100, 99};

      Rst = 1'b0; Start = 1'b0; BaseAddr = '0; Count = '0; Ready = 1'b0;
      #3;
      chk_all_zero("reset");
      @(negedge Clock);
      @(negedge Clock);
      Rst = 1'b1;
      @(negedge Clock);

      for (int v = 0; v < 6; v++) begin
         run_burst(vecs[v].base, vecs[v].cnt, vecs[v].pat, vecs[v].poke, nb, fw, lw);
         chk("vec_nbeats", nb, vecs[v].exp_n);
         chk("vec_first", fw, vecs[v].exp_first);
         chk("vec_last", lw, vecs[v].exp_last);
      end

      // Reset in the middle of a burst
      BaseAddr = 7'd10; Count = 8'd8; Start = 1'b1; Ready = 1'b1;
      acc = 0;
      for (int k = 0; k < 50 && acc < 3; k++) begin
         @(negedge Clock);
         Start = 1'b0;
         if (Valid && Ready) begin
            chkw("rst_pre_data", Data, word_of(10 + acc));
            acc++;
         end
      end
      chk("rst_pre_beats", acc, 3);
      @(posedge Clock);
      #2;
      Rst = 1'b0;
      #1;
      chk_all_zero("midreset");
      dcount = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge Clock);
         if (Done || Valid) dcount++;
      end
      chk("midreset_quiet", dcount, 0);
      Rst = 1'b1;
      Ready = 1'b0;
      @(negedge Clock);
      run_burst(20, 2, 32'hFFFF_FFFF, 1'b0, nb, fw, lw);
      chk("post_rst_nbeats", nb, 2);
      chk("post_rst_first", fw, 20);
      chk("post_rst_last", lw, 21);

      // Randomized bursts against the address-arithmetic model
      for (int r = 0; r < 12; r++) begin
         int b, c;
         b = int'($urandom_range(0, DEPTH - 1));
         c = int'($urandom_range(0, 24));
         run_burst(b, c, $urandom, 1'b0, nb, fw, lw);
         chk("rnd_last", lw, (c == 0) ? -1 : (b + c - 1) % DEPTH);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
